sub180_serial: RTL and testbench

- Bit-serial inverse of the constant-180 adder stage: recovers the 6-bit operand from a 9-bit sum by subtracting the constant K = 180 (binary 0_1011_0100).
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop.
- Sits on the return path of the HW4 datapath. The upstream producer uses a valid/ready handshake, and so does the downstream consumer.

---
 rtl/sub180_serial_if.sv | 45 ++++
 rtl/sub180_serial.sv | 120 ++++++++++++
 tb/tb_sub180_serial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sub180_serial_if.sv
// Handshake bundle for sub180_serial: upstream sum in, recovered operand out.
// Latency: none, pure wiring between producer, serial subtractor and consumer.
// Backpressure: o_ready holds off the producer, i_ready holds off the result.
interface sub180_serial_if #(
   parameter int W_IN  = 9,
   parameter int W_OUT = 6
);
   // upstream side: sum offered to the subtractor
   logic              i_valid;
   logic              o_ready;
   logic [W_IN-1:0]   i_w1;

   // downstream side: recovered operand and range flag
   logic              o_valid;
   logic              i_ready;
   logic [W_OUT-1:0]  o_im1;
   logic              o_err;

   // status
   logic              o_busy;

   // subtractor side
   modport slave (
      input  i_valid,
      input  i_w1,
      input  i_ready,
      output o_ready,
      output o_valid,
      output o_im1,
      output o_err,
      output o_busy
   );

   // producer/consumer side
   modport master (
      output i_valid,
      output i_w1,
      output i_ready,
      input  o_ready,
      input  o_valid,
      input  o_im1,
      input  o_err,
      input  o_busy
   );
endinterface

// File: rtl/sub180_serial.sv
// Bit-serial subtract-K (K=180): recovers the operand from a 9-bit sum, LSB first.
// Latency: accept edge + W_IN RUN cycles, then result held in DONE until i_ready.
// Backpressure: o_ready only in IDLE; DONE holds result stable while i_ready is low.
// Build option: define SUB180_ERRCHK_EN to build the out-of-range flag o_err.
module sub180_serial #(
   parameter int W_IN  = 9,
   parameter int W_OUT = 6,
   parameter int K     = 180
) (
   input  logic           clk,
   input  logic           rst_n,
   sub180_serial_if.slave bus
);

   localparam int              CW    = (W_IN > 1) ? $clog2(W_IN) : 1;
   localparam logic [CW-1:0]   LAST  = CW'(W_IN - 1);
   localparam logic [W_IN-1:0] K_VEC = W_IN'(K);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W_IN-1:0] a_q, a_d;       // minuend, shifted right one bit per RUN cycle
   logic [W_IN-1:0] k_q, k_d;       // subtrahend constant, shifted alongside
   logic [W_IN-1:0] res_q, res_d;   // difference bits enter from the MSB side
   logic            borrow_q, borrow_d;

   logic            accept;
   logic            a0, k0;
   logic            d_bit;
   logic            borrow_nx;

   // Full-subtractor cell operating on the current LSBs
   always_comb begin
      a0        = a_q[0];
      k0        = k_q[0];
      d_bit     = a0 ^ k0 ^ borrow_q;
      borrow_nx = (~a0 & (k0 | borrow_q)) | (k0 & borrow_q);
   end

   assign accept = bus.i_valid && (state_q == IDLE);

   // Next-state and datapath update: load in IDLE, shift in RUN, hold in DONE
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      k_d      = k_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d      = bus.i_w1;
               k_d      = K_VEC;
               res_d    = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            res_d    = {d_bit, res_q[W_IN-1:1]};
            a_d      = a_q >> 1;
            k_d      = k_q >> 1;
            borrow_d = borrow_nx;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // result registers are frozen here so the outputs stay stable
            if (bus.i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         k_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         k_q      <= k_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
      end
   end

   assign bus.o_ready = (state_q == IDLE);
   assign bus.o_busy  = (state_q == RUN);
   assign bus.o_valid = (state_q == DONE);
   // Operand is only presented while a result is held, so partial shifts never leak out
   assign bus.o_im1   = (state_q == DONE) ? res_q[W_OUT-1:0] : '0;

`ifdef SUB180_ERRCHK_EN
   // Out of range: a final borrow means sum < K, nonzero upper bits mean sum > K + 2^W_OUT - 1
   assign bus.o_err = (state_q == DONE) && (borrow_q || (|res_q[W_IN-1:W_OUT]));
`else
   assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_sub180_serial.sv
// Scoreboard bench for sub180_serial: directed sums with hand-computed operands.
// Latency: expected results queued at accept, checked by a monitor at each handshake.
// Backpressure: exercised by holding i_ready low while a result is presented.
module tb_sub180_serial;

   typedef struct {
      logic [5:0] im1;
      logic       err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sub180_serial_if bus ();

   sub180_serial dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int   nvec = 0;
   int   nerr = 0;
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic exp_err(input logic out_of_range);
`ifdef SUB180_ERRCHK_EN
      return out_of_range;
`else
      return 1'b0 & out_of_range;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for o_ready, offer one sum for a single cycle and queue its expected result
   task automatic send(input logic [8:0] w, input logic [5:0] im1, input logic out_of_range);
      int n;
      n = 0;
      while (bus.o_ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) chk("ready_timeout", {31'd0, bus.o_ready}, 32'd1);
      bus.i_valid = 1'b1;
      bus.i_w1    = w;
      sb.push_back('{im1, exp_err(out_of_range)});
      tick();
      bus.i_valid = 1'b0;
   endtask

   // Called just after the accept edge: counts edges (accept included) until o_valid
   task automatic wait_valid(output int lat, output int busy);
      lat  = 1;
      busy = (bus.o_busy === 1'b1) ? 1 : 0;
      while (bus.o_valid !== 1'b1 && lat < 60) begin
         tick();
         lat++;
         if (bus.o_busy === 1'b1) busy++;
      end
      if (lat >= 60) chk("valid_timeout", {31'd0, bus.o_valid}, 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.o_ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) chk("idle_timeout", {31'd0, bus.o_ready}, 32'd1);
   endtask

   // Monitor: compare at every output handshake, then confirm return to IDLE
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            if (sb.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_output: got o_im1=%0d with no result outstanding", bus.o_im1);
            end else begin
               e = sb.pop_front();
               chk("o_im1", {26'd0, bus.o_im1}, {26'd0, e.im1});
               chk("o_err", {31'd0, bus.o_err}, {31'd0, e.err});
               @(negedge clk);
               chk("ready_after_hs", {31'd0, bus.o_ready}, 32'd1);
               chk("valid_after_hs", {31'd0, bus.o_valid}, 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int busy;

      bus.i_valid = 1'b0;
      bus.i_w1    = '0;
      bus.i_ready = 1'b1;
      rst_n       = 1'b0;
      repeat (3) tick();

      // reset state
      chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("rst_o_ready", {31'd0, bus.o_ready}, 32'd1);
      chk("rst_o_busy",  {31'd0, bus.o_busy},  32'd0);
      chk("rst_o_im1",   {26'd0, bus.o_im1},   32'd0);
      chk("rst_o_err",   {31'd0, bus.o_err},   32'd0);
      rst_n = 1'b1;
      tick();

      // first transaction: latency and busy length
      send(9'd180, 6'd0, 1'b0);
      wait_valid(lat, busy);
      chk("latency_180", lat, 32'd10);
      chk("busy_cycles", busy, 32'd9);
      tick();
      chk("ready_after_first", {31'd0, bus.o_ready}, 32'd1);

      // in-range sweep, back to back
      for (int w = 180; w <= 243; w++) begin
         send(9'(w), 6'(w - 180), 1'b0);
      end

      // out-of-range sums
      send(9'd179, 6'd63, 1'b1);
      send(9'd244, 6'd0,  1'b1);
      send(9'd0,   6'd12, 1'b1);
      send(9'd511, 6'd11, 1'b1);
      wait_idle();

      // backpressure: result must hold and a new offer must be ignored
      bus.i_ready = 1'b0;
      send(9'd210, 6'd30, 1'b0);
      wait_valid(lat, busy);
      bus.i_valid = 1'b1;
      bus.i_w1    = 9'd99;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_o_valid", {31'd0, bus.o_valid}, 32'd1);
         chk("bp_o_im1",   {26'd0, bus.o_im1},   32'd30);
         chk("bp_o_err",   {31'd0, bus.o_err},   32'd0);
         chk("bp_o_ready", {31'd0, bus.o_ready}, 32'd0);
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      tick();
      tick();
      chk("bp_no_second_accept", {31'd0, bus.o_busy}, 32'd0);

      // reset while the subtractor is in RUN bit 4
      send(9'd230, 6'd50, 1'b0);
      repeat (3) tick();
      chk("pre_rst_busy", {31'd0, bus.o_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("midrst_o_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("midrst_o_busy",  {31'd0, bus.o_busy},  32'd0);
      chk("midrst_o_ready", {31'd0, bus.o_ready}, 32'd1);
      chk("midrst_o_im1",   {26'd0, bus.o_im1},   32'd0);
      chk("midrst_o_err",   {31'd0, bus.o_err},   32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (12) tick();
      chk("no_stale_valid", {31'd0, bus.o_valid}, 32'd0);

      send(9'd181, 6'd1, 1'b0);
      wait_valid(lat, busy);
      chk("latency_181", lat, 32'd10);
      tick();
      tick();
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
